// File: rtl/uart_rx_buf_ctrl.sv
// UART receive buffer: FWFT byte FIFO with overrun, level watermark and character-timeout interrupts.
// Optional feature macro: UART_RX_TIMEOUT_EN enables the character-timeout counter and FSM.
module uart_rx_buf_ctrl #(
    parameter int DEPTH         = 16,
    parameter int TIMEOUT_TICKS = 640
) (
    input  logic                     clk,
    input  logic                     a_resetn,
    input  logic                     b_tick,
    input  logic                     rx_done,
    input  logic [7:0]               rx_data,
    input  logic                     rx_en,
    input  logic                     rd_en,
    input  logic                     flush,
    input  logic                     ovr_clr,
    input  logic [$clog2(DEPTH):0]   watermark,
    output logic [7:0]               rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overrun,
    output logic                     irq_level,
    output logic                     irq_timeout,
    output logic                     irq
);

    localparam int              AW      = $clog2(DEPTH);
    localparam logic [AW:0]     DEPTH_L = (AW+1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_level;
    logic          r_empty, r_full;
    logic [7:0]    r_rd_data;
    logic          r_overrun, r_irq_level, r_irq_timeout, r_irq;

    logic          w_pop, w_push, w_ovr_evt;
    logic [AW-1:0] w_wr_ptr_nxt, w_rd_ptr_nxt;
    logic [AW:0]   w_level_nxt;
    logic [7:0]    w_head_nxt;
    logic          w_overrun_nxt, w_irq_level_nxt, w_irq_timeout_nxt, w_irq_nxt;

    // FIFO next-state: flush dominates; a full FIFO still accepts a byte when a pop frees a slot.
    always_comb begin
        w_pop        = rd_en & ~r_empty & ~flush;
        w_push       = rx_done & rx_en & ~flush & (~r_full | w_pop);
        w_ovr_evt    = rx_done & rx_en & ~flush & r_full & ~rd_en;
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_level_nxt  = r_level;
        if (flush) begin
            w_wr_ptr_nxt = AW'(0);
            w_rd_ptr_nxt = AW'(0);
            w_level_nxt  = (AW+1)'(0);
        end else begin
            w_wr_ptr_nxt = w_push ? (r_wr_ptr + AW'(1)) : r_wr_ptr;
            w_rd_ptr_nxt = w_pop  ? (r_rd_ptr + AW'(1)) : r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   w_level_nxt = r_level + (AW+1)'(1);
                2'b01:   w_level_nxt = r_level - (AW+1)'(1);
                default: w_level_nxt = r_level;
            endcase
        end
        // The new head may be the byte being written this very cycle.
        if (w_level_nxt == (AW+1)'(0)) begin
            w_head_nxt = 8'h00;
        end else if (w_push && (w_rd_ptr_nxt == r_wr_ptr)) begin
            w_head_nxt = rx_data;
        end else begin
            w_head_nxt = r_mem[w_rd_ptr_nxt];
        end
        w_overrun_nxt   = w_ovr_evt | (r_overrun & ~ovr_clr);
        w_irq_level_nxt = (watermark != (AW+1)'(0)) && (w_level_nxt >= watermark);
        w_irq_nxt       = w_irq_level_nxt | w_irq_timeout_nxt | w_overrun_nxt;
    end

`ifdef UART_RX_TIMEOUT_EN
    typedef enum logic [1:0] {
        T_IDLE    = 2'd0,
        T_COUNT   = 2'd1,
        T_EXPIRED = 2'd2
    } t_state_e;

    localparam int CW = $clog2(TIMEOUT_TICKS + 1);

    t_state_e      r_t_state, w_t_state_nxt;
    logic [CW-1:0] r_tick_cnt, w_tick_cnt_nxt;

    // Timeout state and tick counter registers.
    always_ff @(posedge clk or posedge a_resetn) begin
        if (a_resetn) begin
            r_t_state  <= T_IDLE;
            r_tick_cnt <= CW'(0);
        end else begin
            r_t_state  <= w_t_state_nxt;
            r_tick_cnt <= w_tick_cnt_nxt;
        end
    end

    // Timeout next-state: FIFO activity restarts the count, silence on a non-empty FIFO expires it.
    always_comb begin
        w_t_state_nxt  = r_t_state;
        w_tick_cnt_nxt = r_tick_cnt;
        if (flush) begin
            w_t_state_nxt  = T_IDLE;
            w_tick_cnt_nxt = CW'(0);
        end else if (w_push || w_pop) begin
            w_tick_cnt_nxt = CW'(0);
            w_t_state_nxt  = (w_level_nxt != (AW+1)'(0)) ? T_COUNT : T_IDLE;
        end else begin
            case (r_t_state)
                T_IDLE: begin
                    w_tick_cnt_nxt = CW'(0);
                    w_t_state_nxt  = (r_level != (AW+1)'(0)) ? T_COUNT : T_IDLE;
                end
                T_COUNT: begin
                    if (b_tick && (r_tick_cnt == CW'(TIMEOUT_TICKS - 1))) begin
                        w_t_state_nxt  = T_EXPIRED;
                        w_tick_cnt_nxt = CW'(0);
                    end else if (b_tick) begin
                        w_tick_cnt_nxt = r_tick_cnt + CW'(1);
                    end else begin
                        w_tick_cnt_nxt = r_tick_cnt;
                    end
                end
                T_EXPIRED: w_t_state_nxt = T_EXPIRED;
                default: begin
                    w_t_state_nxt  = T_IDLE;
                    w_tick_cnt_nxt = CW'(0);
                end
            endcase
        end
    end

    assign w_irq_timeout_nxt = (w_t_state_nxt == T_EXPIRED);
`else
    assign w_irq_timeout_nxt = 1'b0;
`endif

    // Storage array; reset only invalidates it through the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= rx_data;
        end
    end

    // Pointer, level, status and interrupt registers.
    always_ff @(posedge clk or posedge a_resetn) begin
        if (a_resetn) begin
            r_wr_ptr      <= AW'(0);
            r_rd_ptr      <= AW'(0);
            r_level       <= (AW+1)'(0);
            r_empty       <= 1'b1;
            r_full        <= 1'b0;
            r_rd_data     <= 8'h00;
            r_overrun     <= 1'b0;
            r_irq_level   <= 1'b0;
            r_irq_timeout <= 1'b0;
            r_irq         <= 1'b0;
        end else begin
            r_wr_ptr      <= w_wr_ptr_nxt;
            r_rd_ptr      <= w_rd_ptr_nxt;
            r_level       <= w_level_nxt;
            r_empty       <= (w_level_nxt == (AW+1)'(0));
            r_full        <= (w_level_nxt == DEPTH_L);
            r_rd_data     <= w_head_nxt;
            r_overrun     <= w_overrun_nxt;
            r_irq_level   <= w_irq_level_nxt;
            r_irq_timeout <= w_irq_timeout_nxt;
            r_irq         <= w_irq_nxt;
        end
    end

    assign rd_data     = r_rd_data;
    assign empty       = r_empty;
    assign full        = r_full;
    assign level       = r_level;
    assign overrun     = r_overrun;
    assign irq_level   = r_irq_level;
    assign irq_timeout = r_irq_timeout;
    assign irq         = r_irq;

endmodule

// File: tb/tb_uart_rx_buf_ctrl.sv
// Randomized self-checking bench for uart_rx_buf_ctrl against a queue-based reference model.
module tb_uart_rx_buf_ctrl;

    localparam int DEPTH = 16;
    localparam int TT    = 640;
    localparam int AW    = 4;

    logic        clk = 1'b0;
    logic        a_resetn = 1'b0;
    logic        b_tick = 1'b0, rx_done = 1'b0, rx_en = 1'b0, rd_en = 1'b0;
    logic        flush = 1'b0, ovr_clr = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic [AW:0] watermark = '0;
    logic [7:0]  rd_data;
    logic        empty, full, overrun, irq_level, irq_timeout, irq;
    logic [AW:0] level;

    always #5 clk = ~clk;

    uart_rx_buf_ctrl #(.DEPTH(DEPTH), .TIMEOUT_TICKS(TT)) dut (
        .clk(clk), .a_resetn(a_resetn), .b_tick(b_tick), .rx_done(rx_done),
        .rx_data(rx_data), .rx_en(rx_en), .rd_en(rd_en), .flush(flush),
        .ovr_clr(ovr_clr), .watermark(watermark), .rd_data(rd_data),
        .empty(empty), .full(full), .level(level), .overrun(overrun),
        .irq_level(irq_level), .irq_timeout(irq_timeout), .irq(irq)
    );

    int         n_checks = 0;
    int         n_errs   = 0;
    string      phase    = "init";
    logic [7:0] q[$];
    bit         m_ovr    = 1'b0;
    int         m_ticks  = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        int lvl;
        bit e_lvl, e_to;
        lvl   = q.size();
        e_lvl = (watermark != 0) && (lvl >= int'(watermark));
`ifdef UART_RX_TIMEOUT_EN
        e_to  = (lvl > 0) && (m_ticks >= TT);
`else
        e_to  = 1'b0;
`endif
        check_val({phase, ".level"},   32'(level),   32'(lvl));
        check_val({phase, ".empty"},   32'(empty),   32'(lvl == 0));
        check_val({phase, ".full"},    32'(full),    32'(lvl == DEPTH));
        check_val({phase, ".rd_data"}, 32'(rd_data), (lvl > 0) ? 32'(q[0]) : 32'd0);
        check_val({phase, ".overrun"}, 32'(overrun), 32'(m_ovr));
        check_val({phase, ".irq_lvl"}, 32'(irq_level), 32'(e_lvl));
        check_val({phase, ".irq_to"},  32'(irq_timeout), 32'(e_to));
        check_val({phase, ".irq"},     32'(irq), 32'(e_lvl | e_to | m_ovr));
    endtask

    // Reference model: applies one clock edge's worth of the rules to the queue.
    task automatic model_edge();
        bit pop, push, ovr_ev, was_full;
        was_full = (q.size() == DEPTH);
        pop      = !flush && rd_en && (q.size() > 0);
        push     = !flush && rx_done && rx_en && (!was_full || pop);
        ovr_ev   = !flush && rx_done && rx_en && was_full && !pop;
        if (flush) begin
            q.delete();
            m_ticks = 0;
        end else begin
            if (pop)  void'(q.pop_front());
            if (push) q.push_back(rx_data);
            if (push || pop) m_ticks = 0;
            else if (b_tick && q.size() > 0) m_ticks++;
        end
        if (ovr_ev) m_ovr = 1'b1;
        else if (ovr_clr) m_ovr = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        rx_done = 1'b0; rd_en = 1'b0; flush = 1'b0; ovr_clr = 1'b0; b_tick = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        rx_done = 1'b1; rx_en = 1'b1; rx_data = b;
        step();
        idle_inputs();
    endtask

    task automatic pop();
        rd_en = 1'b1;
        step();
        idle_inputs();
    endtask

    task automatic apply_reset();
        a_resetn = 1'b1;
        #1;
        q.delete(); m_ovr = 1'b0; m_ticks = 0;
        check_all();
        check_val("rst.empty", 32'(empty), 32'd1);
        check_val("rst.irq",   32'(irq),   32'd0);
        repeat (2) @(posedge clk);
        #1;
        check_all();
        a_resetn = 1'b0;
    endtask

    initial begin
        #100_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        phase = "reset";
        apply_reset();
        push(8'h55);
        check_val("first_edge.level", 32'(level), 32'd1);
        pop();

        phase = "basic";
        push(8'h55); push(8'hAA); push(8'h0F);
        check_val("basic.level3", 32'(level), 32'd3);
        check_val("basic.head55", 32'(rd_data), 32'h55);
        pop();
        check_val("basic.headAA", 32'(rd_data), 32'hAA);
        pop();
        check_val("basic.head0F", 32'(rd_data), 32'h0F);
        pop();
        check_val("basic.empty", 32'(empty), 32'd1);

        phase = "ovr";
        for (int i = 0; i < 17; i++) push(8'(8'h10 + i));
        check_val("ovr.full", 32'(full), 32'd1);
        check_val("ovr.set", 32'(overrun), 32'd1);
        ovr_clr = 1'b1; step(); idle_inputs();
        check_val("ovr.clr", 32'(overrun), 32'd0);
        for (int i = 0; i < 16; i++) begin
            check_val("ovr.data", 32'(rd_data), 32'(8'h10 + i));
            pop();
        end
        check_val("ovr.no17th", 32'(empty), 32'd1);

        phase = "fullpp";
        for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
        rx_done = 1'b1; rx_en = 1'b1; rx_data = 8'hEE; rd_en = 1'b1;
        step(); idle_inputs();
        check_val("fullpp.level", 32'(level), 32'd16);
        check_val("fullpp.ovr", 32'(overrun), 32'd0);
        for (int i = 1; i < 16; i++) begin
            check_val("fullpp.data", 32'(rd_data), 32'(8'h20 + i));
            pop();
        end
        check_val("fullpp.last", 32'(rd_data), 32'hEE);
        pop();

        phase = "wm";
        watermark = 5'd4;
        for (int i = 0; i < 4; i++) push(8'(8'h40 + i));
        check_val("wm.irq_level", 32'(irq_level), 32'd1);
        check_val("wm.irq", 32'(irq), 32'd1);
        pop();
        check_val("wm.drop", 32'(irq_level), 32'd0);
        repeat (3) pop();
        watermark = 5'd0;

        phase = "tmo";
        push(8'h77);
        b_tick = 1'b1;
        repeat (TT - 1) step();
        check_val("tmo.before", 32'(irq_timeout), 32'd0);
        step();
`ifdef UART_RX_TIMEOUT_EN
        check_val("tmo.fire", 32'(irq_timeout), 32'd1);
`else
        check_val("tmo.absent", 32'(irq_timeout), 32'd0);
`endif
        b_tick = 1'b0;
        pop();
        check_val("tmo.clr", 32'(irq_timeout), 32'd0);
        b_tick = 1'b1;
        repeat (TT + 20) step();
        check_val("tmo.idle", 32'(irq_timeout), 32'd0);
        idle_inputs();

        phase = "flush";
        for (int i = 0; i < 17; i++) push(8'(8'h30 + i));
        flush = 1'b1; step(); idle_inputs();
        for (int i = 0; i < 5; i++) push(8'(8'h60 + i));
        check_val("flush.lvl5", 32'(level), 32'd5);
        flush = 1'b1; rx_done = 1'b1; rx_en = 1'b1; rx_data = 8'h99;
        step(); idle_inputs();
        check_val("flush.level", 32'(level), 32'd0);
        check_val("flush.empty", 32'(empty), 32'd1);
        check_val("flush.ovr", 32'(overrun), 32'd1);
        ovr_clr = 1'b1; step(); idle_inputs();

        phase = "midrst";
        watermark = 5'd2;
        push(8'hA1); push(8'hA2); push(8'hA3);
        check_val("midrst.irq_pre", 32'(irq), 32'd1);
        apply_reset();
        push(8'hB1);
        check_val("midrst.accept", 32'(level), 32'd1);
        check_val("midrst.head", 32'(rd_data), 32'hB1);
        watermark = 5'd0;

        for (int p = 0; p < 12; p++) begin
            int mode, n;
            phase = $sformatf("rand%0d", p);
            watermark = (AW+1)'($urandom_range(0, 31));
            if (p == 6) apply_reset();
            mode = p % 4;
            n = (mode == 3) ? 700 : 300;
            for (int c = 0; c < n; c++) begin
                case (mode)
                    0:       begin rx_done = ($urandom_range(0, 99) < 70); rd_en = ($urandom_range(0, 99) < 20); end
                    1:       begin rx_done = ($urandom_range(0, 99) < 20); rd_en = ($urandom_range(0, 99) < 70); end
                    2:       begin rx_done = ($urandom_range(0, 99) < 45); rd_en = ($urandom_range(0, 99) < 45); end
                    default: begin rx_done = 1'b0; rd_en = 1'b0; end
                endcase
                rx_en   = ($urandom_range(0, 9) != 0);
                rx_data = 8'($urandom);
                flush   = (mode != 3) && ($urandom_range(0, 199) == 0);
                ovr_clr = ($urandom_range(0, 29) == 0);
                b_tick  = (mode == 3) ? 1'b1 : ($urandom_range(0, 7) == 0);
                step();
            end
            idle_inputs();
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_buf_ctrl.md
UART_RX_BUF_CTRL -- requirements
Module: uart_rx_buf_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning receive FIFO entries (power of two, 4..64).
REQ-002 The block SHALL have parameter TIMEOUT_TICKS, default 640, meaning b_tick count for the character timeout (4 frames x 160 ticks).
REQ-003 The block SHALL have port clk, input, 1 bit: system clock, all logic on its rising edge.
REQ-004 The block SHALL have port a_resetn, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port b_tick, input, 1 bit: 16x baud tick, one clk wide.
REQ-006 The block SHALL have ports rx_done, input, 1 bit, and rx_data, input, 8 bits: byte-received pulse and byte from the receiver.
REQ-007 The block SHALL have port rx_en, input, 1 bit: accept received bytes.
REQ-008 The block SHALL have port rd_en, input, 1 bit: pop the head entry (host side).
REQ-009 The block SHALL have ports flush, input, 1 bit, and ovr_clr, input, 1 bit: FIFO flush and overrun clear.
REQ-010 The block SHALL have port watermark, input, log2(DEPTH)+1 bits: level interrupt threshold.
REQ-011 The block SHALL have port rd_data, output, 8 bits: head entry, first-word-fall-through.
REQ-012 The block SHALL have ports empty, output, 1 bit; full, output, 1 bit; level, output, log2(DEPTH)+1 bits.
REQ-013 The block SHALL have ports overrun, irq_level, irq_timeout and irq, each output, 1 bit.

Function
REQ-014 Push: rx_done=1 and rx_en=1 and not full SHALL write rx_data at wr_ptr; level, empty and rd_data update on the next cycle.
REQ-015 Pop: rd_en=1 and not empty SHALL advance rd_ptr; rd_en while empty SHALL be ignored with no state change.
REQ-016 Simultaneous push and pop SHALL both occur, level unchanged, including when full; when empty, only the push occurs.
REQ-017 rx_done while full with no pop in the same cycle SHALL drop the byte and set overrun sticky; FIFO contents are unchanged.
REQ-018 rx_done with rx_en=0 SHALL drop the byte without setting overrun.
REQ-019 Pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; level SHALL range 0..DEPTH; full = (level==DEPTH); empty = (level==0).
REQ-020 flush SHALL clear pointers, level and the timeout state in one cycle, taking priority over push and pop in that cycle; overrun is unaffected.
REQ-021 ovr_clr SHALL clear overrun; an overrun event in the same cycle SHALL win and keep it set.
REQ-022 irq_level SHALL be registered as (watermark!=0 and level>=watermark); watermark values above DEPTH never assert it.
REQ-023 The timeout FSM SHALL have states T_IDLE, T_COUNT and T_EXPIRED.
REQ-024 T_IDLE->T_COUNT when level!=0; T_COUNT SHALL count b_tick and reach T_EXPIRED at TIMEOUT_TICKS.
REQ-025 Any push or pop SHALL zero the counter and return the FSM to T_COUNT, or to T_IDLE if the resulting level is 0.
REQ-026 irq_timeout SHALL be 1 only in T_EXPIRED and remain set until a push, pop or flush.
REQ-027 irq SHALL be the registered OR of irq_level, irq_timeout and overrun.

Reset
REQ-028 While a_resetn=1, all outputs SHALL be 0 except empty=1, with pointers, counter and FSM (T_IDLE) cleared; FIFO memory need not be cleared.
REQ-029 Reset asserted mid-operation SHALL discard all buffered bytes; the first clk edge after release SHALL accept traffic.

Configuration
REQ-030 With macro UART_RX_TIMEOUT_EN defined, the timeout counter and FSM SHALL be present as specified above.
REQ-031 Without UART_RX_TIMEOUT_EN, the counter and FSM SHALL be absent, irq_timeout SHALL be tied 0, and TIMEOUT_TICKS SHALL be unused.

Verification
REQ-032 Push 0x55, 0xAA, 0x0F -> level=3, rd_data=0x55; three pops return 0x55, 0xAA, 0x0F; then empty=1.
REQ-033 Push 17 bytes into DEPTH=16 -> full=1, overrun=1, 17th byte absent; ovr_clr -> overrun=0.
REQ-034 Full FIFO, rx_done and rd_en in the same cycle -> level stays 16, overrun=0, new byte is the last entry after wrap.
REQ-035 watermark=4, push 4 bytes -> irq_level=1 and irq=1; one pop -> irq_level=0.
REQ-036 UART_RX_TIMEOUT_EN defined, 1 byte pushed, 640 b_ticks idle -> irq_timeout=1; pop -> irq_timeout=0, FSM in T_IDLE.
REQ-037 flush asserted together with rx_done while level=5 -> level=0, empty=1, overrun unchanged; a_resetn pulse mid-traffic -> empty=1, irq=0.
